lrhls_mul_pipe: RTL and testbench
=================================

Name: lrhls_mul_pipe

Overview:
- Parametrised, pipelined fixed-point multiplier with valid/ready flow control. Successor to the fixed-width single-stage DSP48 multiplier cores in the LRHLS_top datapath.
- Adds per-operand signedness, arbitrary widths, configurable latency, post-multiply shift with optional rounding, and optional saturation with an overflow flag.
- Sits between LR fit-stage operand producers and the accumulation logic.

Parameters:
- A_W, 11, width of operand a.
- B_W, 18, width of operand b.
- A_SIGNED, 0, 1 means a is two's complement; 0 means unsigned.
- B_SIGNED, 1, 1 means b is two's complement.
- OUT_W, 18, result width.
- SHIFT, 0, arithmetic right shift applied to the full product (0..A_W+B_W-1).
- ROUND, 0, 1 means add 2^(SHIFT-1) before the shift (round half up); ignored when SHIFT=0.
- SAT, 0, 1 means clamp to the OUT_W range; 0 means wrap (keep the low OUT_W bits).
- NUM_STAGE, 3, pipeline depth and fixed latency in cycles; must be >=1.

Ports:
- ap_clk, in, 1, clock; all state on the rising edge.
- ap_rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, operand pair valid.
- in_ready, out, 1, block can accept an operand pair this cycle.
- a, in, A_W, operand a.
- b, in, B_W, operand b.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts the result.
- p, out, OUT_W, result.
- ovf, out, 1, pre-clamp value lay outside the OUT_W range; qualified by out_valid.

Behaviour:
- Reset (ap_rst_n=0): all stage valid bits clear immediately (asynchronous). out_valid=0, p=0, ovf=0. in_ready=1 from the first clock after deassertion. Data registers need not be reset except p/ovf.
- Result signedness RS = A_SIGNED | B_SIGNED.
- Arithmetic:
  - Extend each operand per its signedness to A_W+B_W+1 bits.
  - Full product P is exact; it never truncates before the shift.
  - Rounded value R = P + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0), computed with one extra guard bit.
  - S = R >>> SHIFT, sign-filled if RS, zero-filled otherwise.
- Range:
  - If RS, the range is [-2^(OUT_W-1), 2^(OUT_W-1)-1]; otherwise [0, 2^OUT_W-1].
  - ovf=1 iff S lies outside the range.
  - SAT=1: p = the nearest bound when out of range, else S.
  - SAT=0: p = S[OUT_W-1:0].
  - With SAT=0, SHIFT=0 and default widths, p matches the legacy 11ns x 18s -> 18 core bit-for-bit.
- Pipeline: NUM_STAGE register stages, each with a valid bit v[k]. Stage placement of the arithmetic is free; external latency is exactly NUM_STAGE.
- Flow control:
  - adv[N-1] = !v[N-1] | out_ready.
  - adv[k] = !v[k] | adv[k+1].
  - in_ready = adv[0].
  - Stage k loads from k-1 (or from the inputs for k=0) when adv[k]. Its valid becomes the upstream valid (in_valid & in_ready for k=0).
  - Bubbles collapse: stages not holding valid data always advance.
  - in_ready depends combinationally on out_ready (no skid buffer); there is no combinational path from in_valid to out_valid.
- Throughput: one result per cycle while out_ready=1.
- Order is preserved; no data is lost or duplicated under arbitrary out_ready patterns.
- Holding: p/ovf stay stable while out_valid=1 and out_ready=0.
- Simultaneous accept and emit with the pipe full: both occur in the same cycle; occupancy is unchanged.
- Invalid input data (in_valid=0) never raises out_valid.
- Reset mid-stream: in-flight results are discarded; nothing is emitted for them after reset deasserts.

Test Plan:
- Defaults, out_ready=1:
  - a=2047, b=-1 -> p=-2047 (0x3F801), ovf=0, 3 cycles after accept.
  - a=2047, b=131071 -> p=129025 (0x1F801), ovf=1.
- SAT=1, same operands: a=2047, b=131071 -> p=131071 (0x1FFFF), ovf=1. a=2047, b=-131072 -> p=-131072, ovf=1.
- SHIFT=4, B_SIGNED=1, OUT_W=18:
  - ROUND=1: a=3, b=5 -> p=1; a=1, b=-8 -> p=0.
  - ROUND=0: a=3, b=5 -> p=0; a=1, b=-8 -> p=-1.
- NUM_STAGE=3, out_ready=0, in_valid held high with values 1..5:
  - Exactly 3 accepted, then in_ready=0.
  - Raise out_ready: results emitted in order at one per cycle, all 5 delivered, none duplicated.
- Random in_valid/out_ready (10k pairs, all parameter corners including NUM_STAGE=1 and A_SIGNED=B_SIGNED=0) -> scoreboard matches the reference model; p is stable under stall.
- Assert ap_rst_n=0 with 2 results in flight and out_ready=0:
  - out_valid drops asynchronously and p=0.
  - After release, no stale output; in_ready=1.

Source files
------------

// File: rtl/lrhls_mul_pipe.sv
// Pipelined fixed-point multiplier with per-operand signedness, post-multiply
// shift/round, optional saturation and valid/ready backpressure.
module lrhls_mul_pipe #(
    parameter int A_W       = 11,
    parameter int B_W       = 18,
    parameter int A_SIGNED  = 0,
    parameter int B_SIGNED  = 1,
    parameter int OUT_W     = 18,
    parameter int SHIFT     = 0,
    parameter int ROUND     = 0,
    parameter int SAT       = 0,
    parameter int NUM_STAGE = 3
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] p,
    output logic             ovf
);

    localparam int RS     = (A_SIGNED != 0 || B_SIGNED != 0) ? 1 : 0;
    localparam int PW     = A_W + B_W + 1;
    localparam int RW     = PW + 1;
    localparam int CW     = ((RW > OUT_W) ? RW : OUT_W) + 2;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [RW-1:0] RND =
        (ROUND != 0 && SHIFT > 0) ? signed'(RW'(1) << RND_SH) : '0;
    localparam logic signed [CW-1:0] HI =
        (RS != 0) ? signed'((CW'(1) << (OUT_W - 1)) - CW'(1))
                  : signed'((CW'(1) << OUT_W) - CW'(1));
    localparam logic signed [CW-1:0] LO =
        (RS != 0) ? -signed'(CW'(1) << (OUT_W - 1)) : '0;

    function automatic logic signed [PW-1:0] ext_a(input logic [A_W-1:0] x);
        logic fill;
        fill = (A_SIGNED != 0) ? x[A_W-1] : 1'b0;
        return {{(PW - A_W){fill}}, x};
    endfunction

    function automatic logic signed [PW-1:0] ext_b(input logic [B_W-1:0] x);
        logic fill;
        fill = (B_SIGNED != 0) ? x[B_W-1] : 1'b0;
        return {{(PW - B_W){fill}}, x};
    endfunction

    // The guard bit keeps the rounding increment from wrapping the product.
    function automatic logic signed [RW-1:0] round_shift(input logic signed [PW-1:0] prod);
        logic signed [RW-1:0] r;
        r = {prod[PW-1], prod} + RND;
        return r >>> SHIFT;
    endfunction

    function automatic logic [OUT_W:0] saturate(input logic signed [RW-1:0] s);
        logic signed [CW-1:0] sx;
        logic                 hi_ovf;
        logic                 lo_ovf;
        logic [OUT_W-1:0]     q;
        sx     = {{(CW - RW){s[RW-1]}}, s};
        hi_ovf = (sx > HI);
        lo_ovf = (sx < LO);
        q      = sx[OUT_W-1:0];
        if (SAT != 0 && hi_ovf)
            q = HI[OUT_W-1:0];
        else if (SAT != 0 && lo_ovf)
            q = LO[OUT_W-1:0];
        return {hi_ovf | lo_ovf, q};
    endfunction

    logic [NUM_STAGE-1:0] vld_p;
    logic [NUM_STAGE-1:0] adv;
    logic [NUM_STAGE-1:0] vld_up;
    logic signed [PW-1:0] prod_last;

    // A stage advances when it or any stage downstream of it is empty.
    always_comb begin
        logic tail_full;
        tail_full = 1'b1;
        adv       = '0;
        for (int k = NUM_STAGE - 1; k >= 0; k--) begin
            tail_full = tail_full & vld_p[k];
            adv[k]    = !tail_full | out_ready;
        end
    end

    always_comb begin
        vld_up    = vld_p << 1;
        vld_up[0] = in_valid & adv[0];
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_p[NUM_STAGE-1];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_p <= '0;
        end else begin
            for (int k = 0; k < NUM_STAGE; k++)
                if (adv[k])
                    vld_p[k] <= vld_up[k];
        end
    end

    if (NUM_STAGE == 1) begin : g_one
        always_comb prod_last = ext_a(a) * ext_b(b);
    end else begin : g_multi
        logic signed [PW-1:0] a_p0;
        logic signed [PW-1:0] b_p0;

        // ---- stage 0: extended operands ----
        always_ff @(posedge ap_clk) begin
            if (vld_up[0] && adv[0]) begin
                a_p0 <= ext_a(a);
                b_p0 <= ext_b(b);
            end
        end

        if (NUM_STAGE == 2) begin : g_two
            always_comb prod_last = a_p0 * b_p0;
        end else begin : g_deep
            logic signed [PW-1:0] prod_pk [1:NUM_STAGE-2];

            // ---- stage 1: full product, then delay stages ----
            always_ff @(posedge ap_clk) begin
                if (vld_up[1] && adv[1])
                    prod_pk[1] <= a_p0 * b_p0;
                for (int k = 2; k <= NUM_STAGE - 2; k++)
                    if (vld_up[k] && adv[k])
                        prod_pk[k] <= prod_pk[k-1];
            end

            always_comb prod_last = prod_pk[NUM_STAGE-2];
        end
    end

    // ---- last stage: round, shift, range check ----
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            p   <= '0;
            ovf <= 1'b0;
        end else if (vld_up[NUM_STAGE-1] && adv[NUM_STAGE-1]) begin
            {ovf, p} <= saturate(round_shift(prod_last));
        end
    end

endmodule

// File: tb/tb_lrhls_mul_pipe.sv
// Randomised and directed bench for lrhls_mul_pipe over several parameter
// corners, checked against a plain-arithmetic reference model.
module tb_lrhls_mul_pipe;

    localparam int NI = 6;
    localparam int A_SG [NI] = '{0, 0, 0, 0, 0, 1};
    localparam int B_SG [NI] = '{1, 1, 1, 1, 0, 1};
    localparam int OW   [NI] = '{18, 18, 18, 18, 16, 12};
    localparam int SH   [NI] = '{0, 0, 4, 4, 5, 7};
    localparam int RN   [NI] = '{0, 0, 1, 0, 1, 1};
    localparam int ST   [NI] = '{0, 1, 0, 0, 1, 0};
    localparam int NS   [NI] = '{3, 3, 2, 3, 1, 4};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv   [NI];
    logic        ordy [NI];
    logic [10:0] av   [NI];
    logic [17:0] bv   [NI];
    wire         ir   [NI];
    wire         ov   [NI];
    wire         ovf  [NI];
    wire  [17:0] pv   [NI];

    int n_vec;
    int n_err;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        wire [OW[g]-1:0] pw;
        lrhls_mul_pipe #(
            .A_W(11), .B_W(18), .A_SIGNED(A_SG[g]), .B_SIGNED(B_SG[g]),
            .OUT_W(OW[g]), .SHIFT(SH[g]), .ROUND(RN[g]), .SAT(ST[g]),
            .NUM_STAGE(NS[g])
        ) u_dut (
            .ap_clk(clk), .ap_rst_n(rst_n),
            .in_valid(iv[g]), .in_ready(ir[g]),
            .a(av[g]), .b(bv[g]),
            .out_valid(ov[g]), .out_ready(ordy[g]),
            .p(pw), .ovf(ovf[g])
        );
        assign pv[g] = 18'(pw);
    end

    // Reference: exact integer product, round, floor-shift, then range rule.
    function automatic logic [18:0] model(input int i, input logic [10:0] x, input logic [17:0] y);
        longint ax, by, r, s, hi, lo, pe, mask;
        logic   o;
        if (A_SG[i] != 0) ax = longint'($signed(x)); else ax = longint'(x);
        if (B_SG[i] != 0) by = longint'($signed(y)); else by = longint'(y);
        r = ax * by;
        if (RN[i] != 0 && SH[i] > 0) r = r + (longint'(1) << (SH[i] - 1));
        s = r >>> SH[i];
        if (A_SG[i] != 0 || B_SG[i] != 0) begin
            hi = (longint'(1) << (OW[i] - 1)) - 1;
            lo = -(longint'(1) << (OW[i] - 1));
        end else begin
            hi = (longint'(1) << OW[i]) - 1;
            lo = 0;
        end
        o  = (s > hi) || (s < lo);
        pe = s;
        if (ST[i] != 0 && s > hi) pe = hi;
        if (ST[i] != 0 && s < lo) pe = lo;
        mask = (longint'(1) << OW[i]) - 1;
        pe   = pe & mask;
        return {o, pe[17:0]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (ov[i] !== 1'b0 || pv[i] !== 18'd0 || ovf[i] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state[%0d]: out_valid=%b p=%h ovf=%b expected 0/0/0", i, ov[i], pv[i], ovf[i]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (ir[i] !== 1'b1) begin
                n_err++;
                $display("FAIL reset_in_ready[%0d]: in_ready=%b expected 1", i, ir[i]);
            end
        end
    endtask

    task automatic test_mult(input int i, input logic [10:0] x, input logic [17:0] y,
                             input logic [17:0] ep, input logic eo, input string nm);
        int lat;
        @(negedge clk);
        iv[i] = 1'b1; av[i] = x; bv[i] = y; ordy[i] = 1'b1;
        lat = 0;
        #1;
        while (!ir[i] && lat < 10) begin
            @(negedge clk);
            #1;
            lat++;
        end
        @(posedge clk);
        @(negedge clk);
        iv[i] = 1'b0;
        lat = 1;
        while (!ov[i] && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat !== NS[i]) begin
            n_err++;
            $display("FAIL %s latency: got %0d cycles expected %0d", nm, lat, NS[i]);
        end
        n_vec++;
        if (pv[i] !== ep || ovf[i] !== eo) begin
            n_err++;
            $display("FAIL %s: p=%h ovf=%b expected p=%h ovf=%b", nm, pv[i], ovf[i], ep, eo);
        end
        @(posedge clk);
    endtask

    task automatic test_backpressure();
        int   nxt = 1;
        int   got = 0;
        int   last = -1;
        logic gap = 1'b0;
        ordy[0] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            iv[0] = (nxt <= 5); av[0] = 11'(nxt); bv[0] = 18'd1;
            #1;
            if (iv[0] && ir[0]) nxt++;
        end
        n_vec++;
        if (nxt - 1 != 3) begin
            n_err++;
            $display("FAIL bp_accepted: accepted %0d expected 3", nxt - 1);
        end
        n_vec++;
        if (ir[0] !== 1'b0) begin
            n_err++;
            $display("FAIL bp_in_ready_full: in_ready=%b expected 0", ir[0]);
        end
        for (int c = 0; c < 20 && got < 5; c++) begin
            @(negedge clk);
            ordy[0] = 1'b1; iv[0] = (nxt <= 5); av[0] = 11'(nxt);
            #1;
            if (ov[0]) begin
                n_vec++;
                if (pv[0] !== 18'(got + 1)) begin
                    n_err++;
                    $display("FAIL bp_order: p=%h expected %h", pv[0], 18'(got + 1));
                end
                if (last >= 0 && c != last + 1) gap = 1'b1;
                last = c;
                got++;
            end
            if (iv[0] && ir[0]) nxt++;
        end
        n_vec++;
        if (got != 5) begin
            n_err++;
            $display("FAIL bp_count: delivered %0d expected 5", got);
        end
        n_vec++;
        if (gap !== 1'b0) begin
            n_err++;
            $display("FAIL bp_rate: gap=%b expected 0 (one result per cycle)", gap);
        end
        @(negedge clk);
        iv[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_vec++;
            if (ov[0] !== 1'b0) begin
                n_err++;
                $display("FAIL bp_duplicate: out_valid=%b expected 0", ov[0]);
            end
        end
    endtask

    task automatic test_random(input int i, input int n);
        logic [18:0] q[$];
        logic [18:0] exp_v;
        logic [18:0] held;
        logic        held_v = 1'b0;
        int          acc = 0;
        int          cyc = 0;
        while ((acc < n || q.size() > 0) && cyc < 20000) begin
            @(negedge clk);
            if (acc < n) begin
                iv[i] = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 4))
                    0: av[i] = 11'h000;
                    1: av[i] = 11'h7FF;
                    2: av[i] = 11'h400;
                    default: av[i] = 11'($urandom);
                endcase
                case ($urandom_range(0, 5))
                    0: bv[i] = 18'h00000;
                    1: bv[i] = 18'h3FFFF;
                    2: bv[i] = 18'h20000;
                    3: bv[i] = 18'h1FFFF;
                    default: bv[i] = 18'($urandom);
                endcase
                ordy[i] = ($urandom_range(0, 2) != 0);
            end else begin
                iv[i]   = 1'b0;
                ordy[i] = 1'b1;
            end
            #1;
            if (held_v) begin
                n_vec++;
                if (ov[i] !== 1'b1 || {ovf[i], pv[i]} !== held) begin
                    n_err++;
                    $display("FAIL stall_hold[%0d]: valid=%b ovf/p=%h expected 1 %h", i, ov[i], {ovf[i], pv[i]}, held);
                end
            end
            if (ov[i]) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious[%0d]: out_valid=1 with nothing in flight", i);
                end else if (ordy[i]) begin
                    exp_v = q.pop_front();
                    n_vec++;
                    if ({ovf[i], pv[i]} !== exp_v) begin
                        n_err++;
                        $display("FAIL random[%0d]: ovf/p=%h expected %h", i, {ovf[i], pv[i]}, exp_v);
                    end
                end
            end
            held_v = ov[i] && !ordy[i];
            held   = {ovf[i], pv[i]};
            if (iv[i] && ir[i]) begin
                q.push_back(model(i, av[i], bv[i]));
                acc++;
            end
            cyc++;
        end
        iv[i] = 1'b0;
        n_vec++;
        if (acc < n || q.size() != 0) begin
            n_err++;
            $display("FAIL random_timeout[%0d]: accepted %0d of %0d, %0d outstanding", i, acc, n, q.size());
        end
    endtask

    task automatic test_midstream_reset();
        ordy[0] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            iv[0] = 1'b1; av[0] = 11'd7; bv[0] = 18'd3;
        end
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (ov[0] !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_prefill: out_valid=%b expected 1", ov[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (ov[0] !== 1'b0 || pv[0] !== 18'd0) begin
            n_err++;
            $display("FAIL midrst_async: out_valid=%b p=%h expected 0/0", ov[0], pv[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_vec++;
            if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
                n_err++;
                $display("FAIL midrst_stale: out_valid=%b in_ready=%b expected 0/1", ov[0], ir[0]);
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < NI; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1; av[i] = '0; bv[i] = '0;
        end
        test_reset();
        test_mult(0, 11'd2047, 18'h3FFFF, 18'h3F801, 1'b0, "wrap_neg");
        test_mult(0, 11'd2047, 18'h1FFFF, 18'h1F801, 1'b1, "wrap_ovf");
        test_mult(1, 11'd2047, 18'h1FFFF, 18'h1FFFF, 1'b1, "sat_hi");
        test_mult(1, 11'd2047, 18'h20000, 18'h20000, 1'b1, "sat_lo");
        test_mult(2, 11'd3,    18'd5,     18'h00001, 1'b0, "round_pos");
        test_mult(2, 11'd1,    18'h3FFF8, 18'h00000, 1'b0, "round_neg");
        test_mult(3, 11'd3,    18'd5,     18'h00000, 1'b0, "trunc_pos");
        test_mult(3, 11'd1,    18'h3FFF8, 18'h3FFFF, 1'b0, "trunc_neg");
        test_mult(4, 11'd2047, 18'h3FFFF, 18'h0FFFF, 1'b1, "uns_sat");
        test_mult(4, 11'd1,    18'd16,    18'h00001, 1'b0, "uns_round");
        test_backpressure();
        for (int i = 0; i < NI; i++)
            test_random(i, 1700);
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
